ms_wb_splitter: RTL and testbench

- Registered Wishbone classic splitter sitting between the Caravel user-area Wishbone port and the ms_* peripheral slaves (timer, UART, PSRAM controller).
- Decodes address bits [19:16] to one slave and forwards the request.
- Returns the slave response to the master.
- Converts unmapped accesses and hung slaves into a bounded, flagged completion, so the management SoC never stalls.

---
 rtl/ms_wb_pkg.sv | 28 ++
 rtl/ms_wb_tmo_cnt.sv | 42 ++++
 rtl/ms_wb_splitter.sv | 185 ++++++++++++++++++
 tb/tb_ms_wb_splitter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ms_wb_pkg.sv
// Shared types and helpers for the ms_* Wishbone splitter: FSM states,
// miss/timeout read-back value and the adr[19:16] slave decode.
package ms_wb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    RESP
  } state_e;

  localparam logic [31:0] DEFAULT_DATA = 32'hDEADBEEF;
  localparam int          ERR_CNT_W    = 8;
  localparam int          IDX_W        = 3;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } dec_t;

  // Slave k owns the even 64 KiB region adr[19:16] == 2*k; odd nibbles never map.
  function automatic dec_t decode_slave(input logic [31:0] adr, input int n_slaves);
    dec_t d;
    d.idx = adr[19:17];
    d.hit = !adr[16] && (int'(adr[19:17]) < n_slaves);
    return d;
  endfunction

endpackage

// File: rtl/ms_wb_tmo_cnt.sv
// Loadable 16-bit cycle counter with clear/enable and a terminal-count flag
// that is high while the count equals TIMEOUT.
module ms_wb_tmo_cnt #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        clr_i,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  input  logic        en_i,
  output logic        tc_o
);

  localparam logic [15:0] TC_VAL = 16'(TIMEOUT);

  logic [15:0] cnt_q, cnt_d;

  // NOTE: cnt_d gets its hold value first so no path through this block can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/ms_wb_splitter.sv
// Registered Wishbone classic 1:N splitter for the ms_* peripherals; turns
// unmapped or hung accesses into a flagged, bounded completion.
module ms_wb_splitter import ms_wb_pkg::*; #(
  parameter int          N_SLAVES     = 3,
  parameter int          TIMEOUT      = 255,
  parameter logic [31:0] DEFAULT_DATA = ms_wb_pkg::DEFAULT_DATA
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   m_cyc_i,
  input  logic                   m_stb_i,
  input  logic                   m_we_i,
  input  logic [3:0]             m_sel_i,
  input  logic [31:0]            m_adr_i,
  input  logic [31:0]            m_dat_i,
  output logic                   m_ack_o,
  output logic [31:0]            m_dat_o,
  output logic                   m_err_o,
  output logic [N_SLAVES-1:0]    s_cyc_o,
  output logic [N_SLAVES-1:0]    s_stb_o,
  output logic                   s_we_o,
  output logic [3:0]             s_sel_o,
  output logic [31:0]            s_adr_o,
  output logic [31:0]            s_dat_o,
  input  logic [32*N_SLAVES-1:0] s_dat_i,
  input  logic [N_SLAVES-1:0]    s_ack_i,
  output logic                   err_irq_o,
  output logic [31:0]            err_adr_o,
  output logic [ERR_CNT_W-1:0]   err_cnt_o
);

  state_e                state_q, state_d;
  logic                  err_q, err_d;
  logic [N_SLAVES-1:0]   s_stb_q, s_stb_d;
  logic                  s_we_q, s_we_d;
  logic [3:0]            s_sel_q, s_sel_d;
  logic [31:0]           s_adr_q, s_adr_d;
  logic [31:0]           s_dat_q, s_dat_d;
  logic                  m_ack_q, m_ack_d;
  logic                  m_err_q, m_err_d;
  logic [31:0]           m_dat_q, m_dat_d;
  logic                  err_irq_q, err_irq_d;
  logic [31:0]           err_adr_q, err_adr_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

  dec_t        dec;
  logic        accept, sel_ack, tmo_tc;
  logic        cnt_clr, cnt_load, cnt_en;
  logic [31:0] ack_dat;

  assign dec = decode_slave(m_adr_i, N_SLAVES);
  // The ack cycle itself is IDLE; the strobe the master still holds there is the finished request.
  assign accept  = (state_q == IDLE) && m_cyc_i && m_stb_i && !m_ack_q;
  assign sel_ack = |(s_ack_i & s_stb_q);

  always_comb begin
    ack_dat = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (s_stb_q[k]) ack_dat = s_dat_i[32*k +: 32];
    end
  end

  ms_wb_tmo_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (16'd1),
    .en_i       (cnt_en),
    .tc_o       (tmo_tc)
  );

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    s_stb_d   = s_stb_q;
    s_we_d    = s_we_q;
    s_sel_d   = s_sel_q;
    s_adr_d   = s_adr_q;
    s_dat_d   = s_dat_q;
    m_ack_d   = 1'b0;
    m_err_d   = 1'b0;
    m_dat_d   = m_dat_q;
    err_irq_d = 1'b0;
    err_adr_d = err_adr_q;
    err_cnt_d = err_cnt_q;
    cnt_clr   = 1'b0;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    unique case (state_q)
      IDLE: if (accept) begin
        s_we_d  = m_we_i;
        s_sel_d = m_sel_i;
        s_adr_d = m_adr_i;
        s_dat_d = m_dat_i;
        if (dec.hit) begin
          for (int k = 0; k < N_SLAVES; k++) s_stb_d[k] = (dec.idx == IDX_W'(k));
          cnt_load = 1'b1;
          err_d    = 1'b0;
          state_d  = ACTIVE;
        end else begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      ACTIVE: begin
        cnt_en = 1'b1;
        // A master abort beats everything; a selected ack beats a same-cycle timeout.
        if (!m_cyc_i) begin
          s_stb_d = '0;
          cnt_clr = 1'b1;
          state_d = IDLE;
        end else if (sel_ack) begin
          m_dat_d = ack_dat;
          s_stb_d = '0;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (tmo_tc) begin
          s_stb_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        m_ack_d = 1'b1;
        m_err_d = err_q;
        cnt_clr = 1'b1;
        state_d = IDLE;
        if (err_q) begin
          m_dat_d   = DEFAULT_DATA;
          err_irq_d = 1'b1;
          err_adr_d = s_adr_q;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      err_q     <= 1'b0;
      s_stb_q   <= '0;
      s_we_q    <= 1'b0;
      s_sel_q   <= '0;
      s_adr_q   <= '0;
      s_dat_q   <= '0;
      m_ack_q   <= 1'b0;
      m_err_q   <= 1'b0;
      m_dat_q   <= '0;
      err_irq_q <= 1'b0;
      err_adr_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      s_stb_q   <= s_stb_d;
      s_we_q    <= s_we_d;
      s_sel_q   <= s_sel_d;
      s_adr_q   <= s_adr_d;
      s_dat_q   <= s_dat_d;
      m_ack_q   <= m_ack_d;
      m_err_q   <= m_err_d;
      m_dat_q   <= m_dat_d;
      err_irq_q <= err_irq_d;
      err_adr_q <= err_adr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign s_cyc_o   = s_stb_q;
  assign s_stb_o   = s_stb_q;
  assign s_we_o    = s_we_q;
  assign s_sel_o   = s_sel_q;
  assign s_adr_o   = s_adr_q;
  assign s_dat_o   = s_dat_q;
  assign m_ack_o   = m_ack_q;
  assign m_err_o   = m_err_q;
  assign m_dat_o   = m_dat_q;
  assign err_irq_o = err_irq_q;
  assign err_adr_o = err_adr_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_ms_wb_splitter.sv
// Directed bench for ms_wb_splitter: hits, write broadcast, miss, timeout,
// ack/timeout race, error-count saturation, master abort and async reset.
module tb_ms_wb_splitter;

  localparam int TMO = 16;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        m_cyc_i = 1'b0, m_stb_i = 1'b0, m_we_i = 1'b0;
  logic [3:0]  m_sel_i = '0;
  logic [31:0] m_adr_i = '0, m_dat_i = '0;
  logic        m_ack_o, m_err_o;
  logic [31:0] m_dat_o;
  logic [2:0]  s_cyc_o, s_stb_o;
  logic        s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [95:0] s_dat_i = '0;
  logic [2:0]  s_ack_i = '0;
  logic        err_irq_o;
  logic [31:0] err_adr_o;
  logic [7:0]  err_cnt_o;

  int vectors = 0;
  int miscompares = 0;
  int exp_err_cnt = 0;

  // Observations of the most recent access() call.
  int          obs_lat, obs_stb_cycles;
  logic [2:0]  obs_stb_or;
  logic        obs_err, obs_irq, obs_ack_after, obs_irq_after, obs_bad_stb;
  logic [31:0] obs_dat, obs_s_adr, obs_s_dat;
  logic [3:0]  obs_s_sel;
  logic        obs_s_we;

  ms_wb_splitter #(.N_SLAVES(3), .TIMEOUT(TMO), .DEFAULT_DATA(32'hDEADBEEF)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
    .m_ack_o(m_ack_o), .m_dat_o(m_dat_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .err_irq_o(err_irq_o), .err_adr_o(err_adr_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Called #1 after a rising edge. Slave ack_slave (-1: none) acks in its
  // ack_cycle-th strobe cycle (0: never); noise acks non-selected slaves.
  task automatic access(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                        input logic [31:0] wdat, input int ack_slave, input int ack_cycle,
                        input logic [31:0] rdat, input logic [2:0] noise);
    logic [2:0] mask;
    obs_lat = -1; obs_stb_cycles = 0; obs_stb_or = '0; obs_bad_stb = 1'b0;
    obs_err = 1'bx; obs_irq = 1'bx; obs_dat = 'x;
    obs_s_adr = 'x; obs_s_dat = 'x; obs_s_sel = 'x; obs_s_we = 1'bx;
    mask = (ack_slave >= 0) ? ~(3'b001 << ack_slave) : 3'b111;
    s_dat_i = '0;
    if (ack_slave >= 0) s_dat_i[32*ack_slave +: 32] = rdat;
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = we; m_sel_i = sel; m_adr_i = adr; m_dat_i = wdat;
    for (int c = 1; c <= TMO + 10; c++) begin
      @(posedge clk_i); #1;
      if (s_stb_o != 3'b000) begin
        obs_stb_cycles++;
        obs_stb_or |= s_stb_o;
        if ($countones(s_stb_o) != 1 || s_cyc_o !== s_stb_o) obs_bad_stb = 1'b1;
        if (obs_stb_cycles == 1) begin
          obs_s_adr = s_adr_o; obs_s_dat = s_dat_o; obs_s_sel = s_sel_o; obs_s_we = s_we_o;
        end
      end
      s_ack_i = noise & mask;
      if (ack_slave >= 0 && s_stb_o[ack_slave] && obs_stb_cycles == ack_cycle)
        s_ack_i[ack_slave] = 1'b1;
      if (m_ack_o) begin
        obs_lat = c; obs_err = m_err_o; obs_dat = m_dat_o; obs_irq = err_irq_o;
        break;
      end
    end
    s_ack_i = '0; m_cyc_i = 1'b0; m_stb_i = 1'b0;
    @(posedge clk_i); #1;
    obs_ack_after = m_ack_o;
    obs_irq_after = err_irq_o;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    vectors++;
    if ({m_ack_o, m_err_o, err_irq_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_ctl: got %b expected 0", {m_ack_o, m_err_o, err_irq_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o});
    end
    vectors++;
    if ({m_dat_o, err_adr_o, s_adr_o, s_dat_o} !== 128'd0) begin
      miscompares++;
      $display("FAIL reset_data: m_dat %h err_adr %h s_adr %h s_dat %h expected all 0", m_dat_o, err_adr_o, s_adr_o, s_dat_o);
    end
    vectors++;
    if (err_cnt_o !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt_o);
    end
    @(negedge clk_i); rst_n_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_read_hit();
    access(32'h3002_0004, 1'b0, 4'hF, 32'h0, 1, 1, 32'h0000_00A5, 3'b000);
    vectors++;
    if (obs_stb_or !== 3'b010 || obs_bad_stb) begin
      miscompares++;
      $display("FAIL rd_hit_stb: got %b (bad=%b) expected 010", obs_stb_or, obs_bad_stb);
    end
    vectors++;
    if (obs_lat !== 3) begin
      miscompares++;
      $display("FAIL rd_hit_latency: got %0d expected 3", obs_lat);
    end
    vectors++;
    if ({obs_err, obs_irq, obs_dat} !== {2'b00, 32'h0000_00A5}) begin
      miscompares++;
      $display("FAIL rd_hit_resp: err %b irq %b dat %h expected 0 0 000000a5", obs_err, obs_irq, obs_dat);
    end
    vectors++;
    if ({obs_s_adr, obs_s_we, obs_ack_after} !== {32'h3002_0004, 2'b00}) begin
      miscompares++;
      $display("FAIL rd_hit_bcast: adr %h we %b ack_after %b expected 30020004 0 0", obs_s_adr, obs_s_we, obs_ack_after);
    end
  endtask

  task automatic test_write_hit();
    access(32'h3004_0010, 1'b1, 4'b0011, 32'h1234_5678, 2, 2, 32'h0000_0000, 3'b011);
    vectors++;
    if ({obs_s_dat, obs_s_sel, obs_s_we, obs_s_adr} !== {32'h1234_5678, 4'b0011, 1'b1, 32'h3004_0010}) begin
      miscompares++;
      $display("FAIL wr_bcast: dat %h sel %b we %b adr %h expected 12345678 0011 1 30040010",
               obs_s_dat, obs_s_sel, obs_s_we, obs_s_adr);
    end
    vectors++;
    if (obs_stb_or !== 3'b100 || obs_bad_stb || obs_stb_cycles != 2) begin
      miscompares++;
      $display("FAIL wr_stb: got %b over %0d cycles expected 100 over 2", obs_stb_or, obs_stb_cycles);
    end
    vectors++;
    if (obs_lat !== 4 || obs_err !== 1'b0 || obs_irq !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_resp: lat %0d err %b irq %b expected 4 0 0", obs_lat, obs_err, obs_irq);
    end
  endtask

  task automatic test_miss();
    access(32'h3006_0000, 1'b0, 4'hF, 32'h0, -1, 0, 32'h0, 3'b000);
    exp_err_cnt++;
    vectors++;
    if (obs_stb_or !== 3'b000 || obs_lat !== 2) begin
      miscompares++;
      $display("FAIL miss_timing: stb %b lat %0d expected 000 2", obs_stb_or, obs_lat);
    end
    vectors++;
    if ({obs_err, obs_irq, obs_irq_after, obs_dat} !== {3'b110, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("FAIL miss_resp: err %b irq %b irq_after %b dat %h expected 1 1 0 deadbeef",
               obs_err, obs_irq, obs_irq_after, obs_dat);
    end
    vectors++;
    if (err_adr_o !== 32'h3006_0000 || err_cnt_o !== 8'(exp_err_cnt)) begin
      miscompares++;
      $display("FAIL miss_log: adr %h cnt %0d expected 30060000 %0d", err_adr_o, err_cnt_o, exp_err_cnt);
    end
    // Odd region nibble never maps to a slave.
    access(32'h3001_0020, 1'b1, 4'hF, 32'h5555_AAAA, -1, 0, 32'h0, 3'b000);
    exp_err_cnt++;
    vectors++;
    if (obs_stb_or !== 3'b000 || obs_lat !== 2 || obs_err !== 1'b1 || obs_dat !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL miss_odd: stb %b lat %0d err %b dat %h expected 000 2 1 deadbeef",
               obs_stb_or, obs_lat, obs_err, obs_dat);
    end
  endtask

  task automatic test_timeout();
    access(32'h3000_0008, 1'b0, 4'hF, 32'h0, 0, 0, 32'h1111_1111, 3'b000);
    exp_err_cnt++;
    vectors++;
    if (obs_stb_or !== 3'b001 || obs_stb_cycles != TMO) begin
      miscompares++;
      $display("FAIL tmo_stb: stb %b for %0d cycles expected 001 for %0d", obs_stb_or, obs_stb_cycles, TMO);
    end
    vectors++;
    if (obs_lat !== TMO + 2 || obs_err !== 1'b1 || obs_irq !== 1'b1 || obs_dat !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL tmo_resp: lat %0d err %b irq %b dat %h expected %0d 1 1 deadbeef",
               obs_lat, obs_err, obs_irq, obs_dat, TMO + 2);
    end
    vectors++;
    if (err_adr_o !== 32'h3000_0008 || err_cnt_o !== 8'(exp_err_cnt)) begin
      miscompares++;
      $display("FAIL tmo_log: adr %h cnt %0d expected 30000008 %0d", err_adr_o, err_cnt_o, exp_err_cnt);
    end
  endtask

  task automatic test_ack_at_timeout();
    access(32'h3000_000C, 1'b0, 4'hF, 32'h0, 0, TMO, 32'hCAFE_F00D, 3'b000);
    vectors++;
    if (obs_lat !== TMO + 2 || obs_err !== 1'b0 || obs_irq !== 1'b0 || obs_dat !== 32'hCAFE_F00D) begin
      miscompares++;
      $display("FAIL race_resp: lat %0d err %b irq %b dat %h expected %0d 0 0 cafef00d",
               obs_lat, obs_err, obs_irq, obs_dat, TMO + 2);
    end
    vectors++;
    if (err_cnt_o !== 8'(exp_err_cnt)) begin
      miscompares++;
      $display("FAIL race_err_cnt: got %0d expected %0d", err_cnt_o, exp_err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    access(32'h3006_0004, 1'b0, 4'hF, 32'h0, -1, 0, 32'h0, 3'b000);
    exp_err_cnt++;
    access(32'h3002_0008, 1'b0, 4'hF, 32'h0, 1, 1, 32'h0BAD_CAFE, 3'b101);
    vectors++;
    if (obs_lat !== 3 || obs_err !== 1'b0 || obs_dat !== 32'h0BAD_CAFE || obs_stb_or !== 3'b010) begin
      miscompares++;
      $display("FAIL b2b_hit: lat %0d err %b dat %h stb %b expected 3 0 0badcafe 010",
               obs_lat, obs_err, obs_dat, obs_stb_or);
    end
  endtask

  task automatic test_err_saturation();
    for (int i = 0; i < 300; i++) begin
      access(32'h3008_0000 + 32'(i), 1'b0, 4'hF, 32'h0, -1, 0, 32'h0, 3'b000);
      if (exp_err_cnt < 255) exp_err_cnt++;
      vectors++;
      if (err_cnt_o !== 8'(exp_err_cnt)) begin
        miscompares++;
        $display("FAIL sat_step%0d: err_cnt %0d expected %0d", i, err_cnt_o, exp_err_cnt);
      end
    end
    vectors++;
    if (err_cnt_o !== 8'd255 || obs_irq !== 1'b1 || err_adr_o !== 32'h3008_012B) begin
      miscompares++;
      $display("FAIL sat_final: cnt %0d irq %b adr %h expected 255 1 3008012b", err_cnt_o, obs_irq, err_adr_o);
    end
  endtask

  task automatic test_abort_and_reset();
    logic saw_ack;
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b0; m_sel_i = 4'hF; m_adr_i = 32'h3000_0040;
    repeat (3) begin @(posedge clk_i); #1; end
    vectors++;
    if (s_stb_o !== 3'b001) begin
      miscompares++;
      $display("FAIL abort_pre_stb: got %b expected 001", s_stb_o);
    end
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    @(posedge clk_i); #1;
    vectors++;
    if (s_stb_o !== 3'b000 || s_cyc_o !== 3'b000) begin
      miscompares++;
      $display("FAIL abort_stb_clear: stb %b cyc %b expected 000 000", s_stb_o, s_cyc_o);
    end
    saw_ack = 1'b0;
    for (int c = 0; c < TMO + 4; c++) begin
      @(posedge clk_i); #1;
      if (m_ack_o || err_irq_o) saw_ack = 1'b1;
    end
    vectors++;
    if (saw_ack !== 1'b0 || err_cnt_o !== 8'(exp_err_cnt)) begin
      miscompares++;
      $display("FAIL abort_quiet: ack_or_irq %b cnt %0d expected 0 %0d", saw_ack, err_cnt_o, exp_err_cnt);
    end
    // Second access, killed by an asynchronous reset mid-ACTIVE.
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_adr_i = 32'h3004_0000;
    repeat (2) begin @(posedge clk_i); #1; end
    vectors++;
    if (s_stb_o !== 3'b100) begin
      miscompares++;
      $display("FAIL rst_pre_stb: got %b expected 100", s_stb_o);
    end
    #2 rst_n_i = 1'b0;
    #1;
    exp_err_cnt = 0;
    vectors++;
    if (s_stb_o !== 3'b000 || s_cyc_o !== 3'b000 || m_ack_o !== 1'b0 || err_cnt_o !== 8'd0 || m_dat_o !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_async: stb %b cyc %b ack %b cnt %0d dat %h expected 000 000 0 0 0",
               s_stb_o, s_cyc_o, m_ack_o, err_cnt_o, m_dat_o);
    end
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    @(negedge clk_i); rst_n_i = 1'b1;
    saw_ack = 1'b0;
    repeat (4) begin @(posedge clk_i); #1; if (m_ack_o || s_stb_o != 3'b000) saw_ack = 1'b1; end
    vectors++;
    if (saw_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_quiet: spurious ack or strobe after reset");
    end
    access(32'h3002_0000, 1'b0, 4'hF, 32'h0, 1, 1, 32'h7777_0001, 3'b000);
    vectors++;
    if (obs_lat !== 3 || obs_err !== 1'b0 || obs_dat !== 32'h7777_0001) begin
      miscompares++;
      $display("FAIL rst_next_access: lat %0d err %b dat %h expected 3 0 77770001", obs_lat, obs_err, obs_dat);
    end
    access(32'h300A_0000, 1'b0, 4'hF, 32'h0, -1, 0, 32'h0, 3'b000);
    exp_err_cnt++;
    vectors++;
    if (err_cnt_o !== 8'(exp_err_cnt) || obs_err !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_err_cnt: cnt %0d err %b expected %0d 1", err_cnt_o, obs_err, exp_err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_write_hit();
    test_miss();
    test_timeout();
    test_ack_at_timeout();
    test_back_to_back();
    test_err_saturation();
    test_abort_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
